interval_timer: RTL and testbench

Tick-counting interval timer that consumes the TIMERCLK square wave from the clock divider and turns it into a CPU-programmable periodic or one-shot interrupt source. It runs entirely in the MCLK domain, synchronizes and edge-detects TIMERCLK internally, and exposes four 16-bit registers on a simple select/acknowledge bus driven by the 68000 bus glue. IRQ_OUT feeds the interrupt priority encoder.

---
 rtl/interval_timer.sv | 180 ++++++++++++++++++
 tb/tb_interval_timer.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/interval_timer.sv
// interval_timer: tick-counting interval timer in the MCLK domain.
// Synchronizes TIMERCLK, counts its rising edges down from RELOAD and raises a
// pending flag on expiry (periodic or one-shot). Four 16-bit registers sit on a
// select/acknowledge bus: CTRL, STATUS, RELOAD, COUNT.

module interval_timer #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             MCLK_IN,
    input  logic             RESET_ALL_N_IN,
    input  logic             TIMERCLK_IN,
    input  logic             SEL_IN,
    input  logic             WR_IN,
    input  logic [1:0]       ADDR_IN,
    input  logic [WIDTH-1:0] DATA_IN,
    output logic [WIDTH-1:0] DATA_OUT,
    output logic             ACK_OUT,
    output logic             IRQ_OUT,
    input  logic             IACK_IN
);

    localparam logic [1:0] AddrCtrl   = 2'd0;
    localparam logic [1:0] AddrStatus = 2'd1;
    localparam logic [1:0] AddrReload = 2'd2;
    localparam logic [1:0] AddrCount  = 2'd3;

    // Tick synchronizer state
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] fill_q;
    logic                   prev_q;
    logic                   armed_q;
    logic                   tick;

    // Register file state
    logic             en_q, en_d;
    logic             auto_q, auto_d;
    logic             ie_q, ie_d;
    logic             pend_q, pend_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             expire;

    // Bus state
    logic             ack_q, ack_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic [WIDTH-1:0] rdata;
    logic             bus_exec;
    logic             wr_ctrl, wr_status, wr_reload, wr_count;

    // Shift TIMERCLK through the sync chain; arm only once a genuine low has been
    // seen after reset, so a level already high at release never counts as a tick.
    always_ff @(posedge MCLK_IN or negedge RESET_ALL_N_IN) begin
        if (!RESET_ALL_N_IN) begin
            sync_q  <= '0;
            fill_q  <= '0;
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], TIMERCLK_IN};
            fill_q  <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            prev_q  <= sync_q[SYNC_STAGES-1];
            armed_q <= armed_q | (fill_q[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES-1]);
        end
    end

    // Rising edge of the synchronized level; falling edges are ignored
    assign tick = armed_q & sync_q[SYNC_STAGES-1] & ~prev_q;

    // An access executes once per SEL assertion, on the first edge it is seen
    assign bus_exec  = SEL_IN & ~ack_q;
    assign wr_ctrl   = bus_exec & WR_IN & (ADDR_IN == AddrCtrl);
    assign wr_status = bus_exec & WR_IN & (ADDR_IN == AddrStatus);
    assign wr_reload = bus_exec & WR_IN & (ADDR_IN == AddrReload);
    assign wr_count  = bus_exec & WR_IN & (ADDR_IN == AddrCount);

    // Timer next state: tick uses pre-write CTRL, then bus writes layer on top
    always_comb begin
        en_d     = en_q;
        auto_d   = auto_q;
        ie_d     = ie_q;
        pend_d   = pend_q;
        reload_d = reload_q;
        count_d  = count_q;
        expire   = 1'b0;

        if (tick && en_q) begin
            if (count_q != '0) begin
                count_d = count_q - WIDTH'(1);
            end else begin
                expire = 1'b1;
                if (auto_q) begin
                    count_d = reload_q;
                end else begin
                    en_d = 1'b0;
                end
            end
        end

        if (wr_ctrl) begin
            en_d   = DATA_IN[0];
            auto_d = DATA_IN[1];
            ie_d   = DATA_IN[2];
            // Only an enable transition reloads; rewriting EN=1 keeps the count
            if (!en_q && DATA_IN[0]) begin
                count_d = reload_q;
            end
        end

        if (wr_reload) begin
            reload_d = DATA_IN;
        end

        // Direct COUNT load overrides any tick on the same edge
        if (wr_count) begin
            count_d = DATA_IN;
        end

        if ((wr_status && DATA_IN[0]) || IACK_IN) begin
            pend_d = 1'b0;
        end
        // Expiry beats a simultaneous clear so no interrupt is lost
        if (expire) begin
            pend_d = 1'b1;
        end
    end

    // Timer register state
    always_ff @(posedge MCLK_IN or negedge RESET_ALL_N_IN) begin
        if (!RESET_ALL_N_IN) begin
            en_q     <= 1'b0;
            auto_q   <= 1'b0;
            ie_q     <= 1'b0;
            pend_q   <= 1'b0;
            reload_q <= '0;
            count_q  <= '0;
        end else begin
            en_q     <= en_d;
            auto_q   <= auto_d;
            ie_q     <= ie_d;
            pend_q   <= pend_d;
            reload_q <= reload_d;
            count_q  <= count_d;
        end
    end

    // Read mux of live register values
    always_comb begin
        rdata = '0;
        unique case (ADDR_IN)
            AddrCtrl:   rdata[2:0] = {ie_q, auto_q, en_q};
            AddrStatus: rdata[0]   = pend_q;
            AddrReload: rdata      = reload_q;
            AddrCount:  rdata      = count_q;
            default:    rdata      = '0;
        endcase
    end

    // Bus handshake next state: ACK holds until SEL is seen low
    always_comb begin
        ack_d      = bus_exec | (ack_q & SEL_IN);
        data_out_d = (bus_exec && !WR_IN) ? rdata : data_out_q;
    end

    // Bus handshake state
    always_ff @(posedge MCLK_IN or negedge RESET_ALL_N_IN) begin
        if (!RESET_ALL_N_IN) begin
            ack_q      <= 1'b0;
            data_out_q <= '0;
        end else begin
            ack_q      <= ack_d;
            data_out_q <= data_out_d;
        end
    end

    assign DATA_OUT = data_out_q;
    assign ACK_OUT  = ack_q;
    assign IRQ_OUT  = pend_q & ie_q;

endmodule

// File: tb/tb_interval_timer.sv
// Self-checking bench for interval_timer: directed scenarios followed by random
// register traffic, all compared against a register-level model of the timer.

module tb_interval_timer;

    logic        clk;
    logic        rst_n;
    logic        timerclk;
    logic        sel;
    logic        wr;
    logic [1:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        ack;
    logic        irq;
    logic        iack;

    int checks;
    int failures;

    // Reference model: programmer-visible register contents
    logic        m_en, m_auto, m_ie, m_pend;
    logic [15:0] m_reload, m_count;

    logic [15:0] rd;

    interval_timer #(
        .WIDTH       (16),
        .SYNC_STAGES (2)
    ) dut (
        .MCLK_IN        (clk),
        .RESET_ALL_N_IN (rst_n),
        .TIMERCLK_IN    (timerclk),
        .SEL_IN         (sel),
        .WR_IN          (wr),
        .ADDR_IN        (addr),
        .DATA_IN        (wdata),
        .DATA_OUT       (rdata),
        .ACK_OUT        (ack),
        .IRQ_OUT        (irq),
        .IACK_IN        (iack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void m_reset();
        m_en = 1'b0; m_auto = 1'b0; m_ie = 1'b0; m_pend = 1'b0;
        m_reload = 16'd0; m_count = 16'd0;
    endfunction

    function automatic void m_tick();
        if (m_en) begin
            if (m_count != 16'd0) begin
                m_count = m_count - 16'd1;
            end else begin
                m_pend = 1'b1;
                if (m_auto) m_count = m_reload;
                else        m_en = 1'b0;
            end
        end
    endfunction

    function automatic void m_write(input logic [1:0] a, input logic [15:0] d);
        case (a)
            2'd0: begin
                if (!m_en && d[0]) m_count = m_reload;
                m_en = d[0]; m_auto = d[1]; m_ie = d[2];
            end
            2'd1: if (d[0]) m_pend = 1'b0;
            2'd2: m_reload = d;
            default: m_count = d;
        endcase
    endfunction

    function automatic logic [15:0] m_read(input logic [1:0] a);
        case (a)
            2'd0:    return {13'd0, m_ie, m_auto, m_en};
            2'd1:    return {15'd0, m_pend};
            2'd2:    return m_reload;
            default: return m_count;
        endcase
    endfunction

    // One bus access, starting right after a falling clock edge
    task automatic bus_xfer(input logic w, input logic [1:0] a, input logic [15:0] d,
                            output logic [15:0] q);
        int n;
        sel = 1'b1; wr = w; addr = a; wdata = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack && n < 16);
        chk("ack_latency", 16'(n), 16'd1);
        q = rdata;
        sel = 1'b0; wr = 1'b0;
        @(negedge clk);
        chk("ack_release", {15'd0, ack}, 16'd0);
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [15:0] d);
        logic [15:0] dummy;
        bus_xfer(1'b1, a, d, dummy);
        m_write(a, d);
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] a);
        logic [15:0] q;
        bus_xfer(1'b0, a, 16'd0, q);
        chk(tag, q, m_read(a));
    endtask

    task automatic chk_irq(input string tag);
        chk(tag, {15'd0, irq}, {15'd0, m_pend & m_ie});
    endtask

    task automatic tick(input int half);
        timerclk = 1'b1;
        repeat (half) @(negedge clk);
        timerclk = 1'b0;
        repeat (half) @(negedge clk);
        m_tick();
    endtask

    // Raise TIMERCLK so its tick lands on the same edge as a bus write
    task automatic collide(input logic [1:0] a, input logic [15:0] d);
        logic [15:0] dummy;
        timerclk = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus_xfer(1'b1, a, d, dummy);
        timerclk = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic iack_pulse();
        iack = 1'b1;
        @(negedge clk);
        iack = 1'b0;
        m_pend = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0; timerclk = 1'b0; sel = 1'b0; wr = 1'b0; addr = 2'd0;
        wdata = 16'd0; iack = 1'b0;
        m_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Reset values
        chk("rst_data_out", rdata, 16'd0);
        chk("rst_ack", {15'd0, ack}, 16'd0);
        chk("rst_irq", {15'd0, irq}, 16'd0);
        for (int a = 0; a < 4; a++) rd_chk("rst_reg", 2'(a));

        // Periodic: RELOAD=4, 40-MCLK TIMERCLK period
        wr_reg(2'd2, 16'd4);
        wr_reg(2'd0, 16'h7);
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 5; k++) begin
                rd_chk("per_count", 2'd3);
                chk_irq("per_irq_low");
                tick(20);
            end
            chk("per_irq_set", {15'd0, irq}, 16'd1);
            rd_chk("per_status", 2'd1);
            iack_pulse();
            chk("per_irq_iack", {15'd0, irq}, 16'd0);
        end

        // One-shot: RELOAD=2, EN|IE
        wr_reg(2'd0, 16'h0);
        wr_reg(2'd2, 16'd2);
        wr_reg(2'd0, 16'h5);
        repeat (3) tick(4);
        rd_chk("os_status", 2'd1);
        bus_xfer(1'b0, 2'd0, 16'd0, rd);
        chk("os_ctrl", rd, 16'h4);
        rd_chk("os_count", 2'd3);
        chk_irq("os_irq");
        wr_reg(2'd1, 16'd1);
        repeat (2) tick(4);
        rd_chk("os_status_after", 2'd1);
        rd_chk("os_count_after", 2'd3);

        // Masking: periodic with IE=0, then enable IE
        wr_reg(2'd0, 16'h0);
        wr_reg(2'd2, 16'd1);
        wr_reg(2'd0, 16'h3);
        repeat (2) tick(4);
        chk("mask_irq_low", {15'd0, irq}, 16'd0);
        rd_chk("mask_status", 2'd1);
        wr_reg(2'd0, 16'h7);
        chk("mask_irq_high", {15'd0, irq}, 16'd1);
        rd_chk("mask_count_kept", 2'd3);
        iack_pulse();

        // Collision: COUNT write wins over tick
        wr_reg(2'd0, 16'h0);
        wr_reg(2'd1, 16'd1);
        wr_reg(2'd2, 16'd3);
        wr_reg(2'd0, 16'h3);
        collide(2'd3, 16'd9);
        m_tick();
        m_write(2'd3, 16'd9);
        rd_chk("coll_count", 2'd3);
        // Collision: expiry wins over W1C
        wr_reg(2'd3, 16'd0);
        rd_chk("coll_pend_pre", 2'd1);
        collide(2'd1, 16'd1);
        m_write(2'd1, 16'd1);
        m_tick();
        rd_chk("coll_pend", 2'd1);
        rd_chk("coll_reload", 2'd3);

        // RELOAD=0 with AUTO: pending on every tick
        wr_reg(2'd0, 16'h0);
        wr_reg(2'd1, 16'd1);
        wr_reg(2'd2, 16'd0);
        wr_reg(2'd0, 16'h3);
        for (int k = 0; k < 3; k++) begin
            tick(4);
            rd_chk("r0_pend", 2'd1);
            wr_reg(2'd1, 16'd1);
            rd_chk("r0_clear", 2'd1);
        end

        // Ticks while disabled leave COUNT alone
        wr_reg(2'd0, 16'h0);
        wr_reg(2'd3, 16'd5);
        repeat (3) tick(4);
        rd_chk("dis_count", 2'd3);

        // Full-range RELOAD: expiry reloads 0xFFFF, then counts down cleanly
        wr_reg(2'd2, 16'hFFFF);
        wr_reg(2'd0, 16'h3);
        wr_reg(2'd3, 16'd1);
        repeat (2) tick(4);
        rd_chk("ffff_count", 2'd3);
        rd_chk("ffff_pend", 2'd1);
        tick(4);
        rd_chk("ffff_dec", 2'd3);

        // Random register traffic against the model
        wr_reg(2'd0, 16'h0);
        wr_reg(2'd1, 16'd1);
        for (int i = 0; i < 150; i++) begin
            int op;
            op = int'($urandom_range(0, 9));
            case (op)
                0: wr_reg(2'd2, 16'($urandom_range(0, 5)));
                1: wr_reg(2'd0, 16'($urandom_range(0, 7)));
                2: wr_reg(2'd3, 16'($urandom_range(0, 6)));
                3: wr_reg(2'd1, 16'($urandom_range(0, 1)));
                4: iack_pulse();
                default: tick(int'($urandom_range(3, 6)));
            endcase
            rd_chk("rand_reg", 2'($urandom_range(0, 3)));
            chk_irq("rand_irq");
        end

        // Reset in the middle of an access, with a pending interrupt and COUNT=7
        wr_reg(2'd0, 16'h0);
        wr_reg(2'd1, 16'd1);
        wr_reg(2'd2, 16'd0);
        wr_reg(2'd0, 16'h7);
        tick(4);
        chk("mr_irq_pre", {15'd0, irq}, 16'd1);
        wr_reg(2'd3, 16'd7);
        rd_chk("mr_count_pre", 2'd3);
        timerclk = 1'b1;
        sel = 1'b1; wr = 1'b1; addr = 2'd2; wdata = 16'h55;
        @(posedge clk);
        #1;
        chk("mr_ack_mid", {15'd0, ack}, 16'd1);
        rst_n = 1'b0;
        #1;
        chk("mr_ack", {15'd0, ack}, 16'd0);
        chk("mr_irq", {15'd0, irq}, 16'd0);
        chk("mr_data_out", rdata, 16'd0);
        sel = 1'b0; wr = 1'b0;
        m_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rd_chk("mr_count", 2'd3);
        rd_chk("mr_reload", 2'd2);
        rd_chk("mr_ctrl", 2'd0);
        rd_chk("mr_status", 2'd1);
        // TIMERCLK high through release must not count as a tick
        wr_reg(2'd2, 16'd3);
        wr_reg(2'd0, 16'h1);
        repeat (10) @(negedge clk);
        rd_chk("mr_no_tick", 2'd3);
        timerclk = 1'b0;
        repeat (5) @(negedge clk);
        tick(4);
        rd_chk("mr_first_tick", 2'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
